// File: rtl/gate_model_tester.sv
// LFSR stimulus generator and MISR response compactor for a combinational gate model.
// Each pattern is held for SETTLE cycles and then captured in one further cycle.
module gate_model_tester #(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned SIG_W  = 16,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pattern_idx,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned ST_W = $clog2(SETTLE + 1);
    localparam logic [SIG_W-1:0] POLY = SIG_W'(32'hB400);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IN_W-1:0]  stim_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic [SIG_W-1:0] sig_nxt;
    logic [ST_W-1:0]  settle, settle_nxt;
    logic             busy_nxt, done_nxt;

    logic             fb_c;
    logic [IN_W-1:0]  lfsr_adv_c;
    logic [SIG_W-1:0] misr_c;
    logic [CNT_W-1:0] idx_inc_c;

    // Next-pattern and compaction datapath; stim is the LFSR register itself.
    assign fb_c       = stim[IN_W-1] ^ stim[4] ^ stim[2] ^ stim[0];
    assign lfsr_adv_c = {stim[IN_W-2:0], fb_c};
    assign misr_c     = {signature[SIG_W-2:0], 1'b0}
                      ^ (signature[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(resp);
    assign idx_inc_c  = pattern_idx + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stim        <= '0;
            count       <= '0;
            pattern_idx <= '0;
            signature   <= '0;
            settle      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            stim        <= stim_nxt;
            count       <= count_nxt;
            pattern_idx <= idx_nxt;
            signature   <= sig_nxt;
            settle      <= settle_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stim_nxt   = stim;
        count_nxt  = count;
        idx_nxt    = pattern_idx;
        sig_nxt    = signature;
        settle_nxt = settle;
        busy_nxt   = busy;
        done_nxt   = done;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    count_nxt  = num_patterns;
                    // An all-zero seed would lock the LFSR, so substitute 1.
                    stim_nxt   = (seed == '0) ? IN_W'(1) : seed;
                    sig_nxt    = '0;
                    idx_nxt    = '0;
                    settle_nxt = '0;
                    if (num_patterns != '0) begin
                        state_nxt = APPLY;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            APPLY: begin
                settle_nxt = settle + ST_W'(1);
                if (settle == SETTLE_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                sig_nxt    = misr_c;
                stim_nxt   = lfsr_adv_c;
                idx_nxt    = idx_inc_c;
                settle_nxt = '0;
                // Ending on equality lets the maximum count run without wrapping.
                if (idx_inc_c == count) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = APPLY;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_model_tester.sv
// Directed bench for gate_model_tester: vector table of whole runs plus
// hand-written sequences for stim timing, start-while-busy and async reset.
module tb_gate_model_tester;

    localparam int unsigned IN_W   = 14;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned SIG_W  = 16;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int LIM = 1000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [IN_W-1:0]  seed;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic [OUT_W-1:0] resp_v;
    logic             model_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pattern_idx;
    logic [SIG_W-1:0] signature;

    int n_checks = 0;
    int n_fail   = 0;

    gate_model_tester #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
        .seed(seed), .stim(stim), .resp(resp), .busy(busy), .done(done),
        .pattern_idx(pattern_idx), .signature(signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational gate model for the closed-loop run.
    function automatic logic [9:0] fmodel(input logic [13:0] s);
        return (s[9:0] ^ {s[13:10], s[13:8]}) ^ {s[0] & s[5], 9'b0} ^ {9'b0, s[13] | s[7]};
    endfunction

    function automatic logic [13:0] lfsr_step(input logic [13:0] x);
        return {x[12:0], x[13] ^ x[4] ^ x[2] ^ x[0]};
    endfunction

    function automatic logic [13:0] lfsr_adv(input logic [13:0] x, input int n);
        logic [13:0] y = (x == 14'd0) ? 14'd1 : x;
        for (int i = 0; i < n; i++) y = lfsr_step(y);
        return y;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ {6'b0, r};
    endfunction

    assign resp = model_en ? fmodel(stim) : resp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start and wait for done; edges counts clock edges from the start edge.
    task automatic run(input logic [13:0] sd, input logic [15:0] n,
                       output int edges, output logic saw_busy);
        @(negedge clk);
        seed = sd;
        num_patterns = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        saw_busy = busy;
        while (!done && edges < LIM) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) saw_busy = 1'b1;
        end
    endtask

    typedef struct {
        logic [13:0] seed;
        logic [15:0] n;
        logic [9:0]  resp;
        logic [15:0] exp_sig;
        logic [13:0] exp_stim;
    } vec_t;

    vec_t vecs[9];
    logic [13:0] seq_exp[9];

    initial begin
        int edges;
        logic saw_busy;
        logic [13:0] st;
        logic [15:0] sig;

        vecs[0] = '{14'h0001, 16'd3,   10'h000, 16'h0000, 14'h000E};
        vecs[1] = '{14'h02A5, 16'd100, 10'h000, 16'h0000, lfsr_adv(14'h02A5, 100)};
        vecs[2] = '{14'h0001, 16'd1,   10'h001, 16'h0001, 14'h0003};
        vecs[3] = '{14'h0001, 16'd2,   10'h001, 16'h0003, 14'h0007};
        vecs[4] = '{14'h0001, 16'd17,  10'h001, 16'h4BFF, lfsr_adv(14'h0001, 17)};
        vecs[5] = '{14'h1234, 16'd0,   10'h3FF, 16'h0000, 14'h1234};
        vecs[6] = '{14'h0000, 16'd0,   10'h001, 16'h0000, 14'h0001};
        vecs[7] = '{14'h0000, 16'd1,   10'h3FF, 16'h03FF, 14'h0003};
        vecs[8] = '{14'h3FFF, 16'd2,   10'h3FF, 16'h0401, lfsr_adv(14'h3FFF, 2)};
        seq_exp = '{14'h1, 14'h1, 14'h1, 14'h3, 14'h3, 14'h3, 14'h7, 14'h7, 14'h7};

        rst_n = 1'b0;
        start = 1'b0;
        seed = '0;
        num_patterns = '0;
        resp_v = '0;
        model_en = 1'b0;
        #12;
        check("reset_stim", 32'(stim), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_sig", 32'(signature), 32'h0);
        check("reset_idx", 32'(pattern_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact stim sequence and done latency for seed 1, three patterns.
        @(negedge clk);
        seed = 14'h0001;
        num_patterns = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("seq_stim_%0d", k), 32'(stim), 32'(seq_exp[k]));
            check($sformatf("seq_notdone_%0d", k), 32'(done), 32'h0);
            @(posedge clk);
            #1;
        end
        check("seq_done", 32'(done), 32'h1);
        check("seq_busy", 32'(busy), 32'h0);
        check("seq_idx", 32'(pattern_idx), 32'd3);

        for (int i = 0; i < 9; i++) begin
            resp_v = vecs[i].resp;
            run(vecs[i].seed, vecs[i].n, edges, saw_busy);
            check($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].n) * 3 + 1);
            check($sformatf("v%0d_done", i), 32'(done), 32'h1);
            check($sformatf("v%0d_busy_seen", i), 32'(saw_busy), 32'(vecs[i].n != 0));
            check($sformatf("v%0d_sig", i), 32'(signature), 32'(vecs[i].exp_sig));
            check($sformatf("v%0d_idx", i), 32'(pattern_idx), 32'(vecs[i].n));
            check($sformatf("v%0d_stim", i), 32'(stim), 32'(vecs[i].exp_stim));
        end

        // A start pulse mid-run must not disturb the run in progress.
        resp_v = 10'h001;
        @(negedge clk);
        seed = 14'h0055;
        num_patterns = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
            edges++;
        end
        @(negedge clk);
        seed = 14'h3333;
        num_patterns = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges++;
        while (!done && edges < LIM) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("busy_start_latency", 32'(edges), 32'd16);
        check("busy_start_idx", 32'(pattern_idx), 32'd5);
        check("busy_start_sig", 32'(signature), 32'h001F);
        check("busy_start_stim", 32'(stim), 32'(lfsr_adv(14'h0055, 5)));

        // Closed loop against the stand-in gate model.
        model_en = 1'b1;
        run(14'h1ACE, 16'd200, edges, saw_busy);
        st = 14'h1ACE;
        sig = 16'h0;
        for (int p = 0; p < 200; p++) begin
            sig = misr_step(sig, fmodel(st));
            st = lfsr_step(st);
        end
        check("loop_latency", 32'(edges), 32'd601);
        check("loop_sig", 32'(signature), 32'(sig));
        check("loop_stim", 32'(stim), 32'(st));
        model_en = 1'b0;

        // Asynchronous reset in the second pattern's APPLY phase.
        resp_v = 10'h001;
        @(negedge clk);
        seed = 14'h0001;
        num_patterns = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_sig", 32'(signature), 32'h1);
        check("pre_rst_idx", 32'(pattern_idx), 32'h1);
        check("pre_rst_stim", 32'(stim), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stim", 32'(stim), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_sig", 32'(signature), 32'h0);
        check("arst_idx", 32'(pattern_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_busy", 32'(busy), 32'h0);
        check("post_rst_idle_stim", 32'(stim), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
